// File: rtl/adder3.sv
// Three-input one-bit adder with per-bit synchronizer chain on SW.
// LEDR, HEX0 and CHG are registered and update together from the last sync stage.
module adder3 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [2:0] SW,
   output logic [1:0] LEDR,
   output logic [6:0] HEX0,
   output logic       CHG
);

   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic [2:0]                  sw_sync;
   logic [1:0]                  sum;
   logic [6:0]                  seg;

   assign sw_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sum = {1'b0, sw_sync[0]} + {1'b0, sw_sync[1]} + {1'b0, sw_sync[2]};
   end

   // Active-low segments, bit 6..0 = g..a.
   always_comb begin
      seg = 7'b1000000;
      case (sum)
         2'd0: seg = 7'b1000000;
         2'd1: seg = 7'b1111001;
         2'd2: seg = 7'b0100100;
         2'd3: seg = 7'b0110000;
         default: seg = 7'b1000000;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q <= '0;
         LEDR   <= 2'b00;
         HEX0   <= 7'b1000000;
         CHG    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], SW};
         LEDR   <= sum;
         HEX0   <= seg;
         CHG    <= (sum != LEDR);
      end
   end

endmodule

// File: tb/tb_adder3.sv
// Self-checking bench for adder3: delay-queue reference model checked every
// cycle, plus directed literal checks for sweep, latency, reset and glitch cases.
module tb_adder3;

   localparam int S = 2;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N  = 1'b1;
   logic [2:0] SW       = 3'd0;
   logic [1:0] LEDR;
   logic [6:0] HEX0;
   logic       CHG;

   always #5 CLOCK_50 = ~CLOCK_50;

   adder3 #(.SYNC_STAGES(S)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .SW       (SW),
      .LEDR     (LEDR),
      .HEX0     (HEX0),
      .CHG      (CHG)
   );

   int total  = 0;
   int passed = 0;
   bit mon_en = 1'b0;

   logic [6:0] seg_tab [4];
   logic [1:0] sweep_tab [8];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [1:0] ones(input logic [2:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 3; i++) if (v[i]) n++;
      return 2'(n);
   endfunction

   // Reference: the value seen at each rising edge reaches LEDR S edges later.
   logic [2:0] hist[$];
   logic [1:0] m_ledr = 2'b00;
   logic       m_chg  = 1'b0;
   logic [1:0] m_next;

   always @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         hist = {};
         for (int i = 0; i < S; i++) hist.push_back(3'd0);
         m_ledr = 2'b00;
         m_chg  = 1'b0;
      end else if (hist.size() == S) begin
         m_next = ones(hist.pop_front());
         hist.push_back(SW);
         m_chg  = (m_next != m_ledr);
         m_ledr = m_next;
      end
   end

   always @(negedge CLOCK_50) begin
      if (mon_en) begin
         check("model_ledr", 16'(LEDR), 16'(m_ledr));
         check("model_hex0", 16'(HEX0), 16'(seg_tab[m_ledr]));
         check("model_chg",  16'(CHG),  16'(m_chg));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   initial begin
      seg_tab   = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
      sweep_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

      // reset state
      #1 RESET_N = 1'b0;
      mon_en = 1'b1;
      #1;
      check("rst_ledr", 16'(LEDR), 16'h0);
      check("rst_hex0", 16'(HEX0), 16'(7'b1000000));
      check("rst_chg",  16'(CHG),  16'h0);
      cycles(2);
      RESET_N = 1'b1;

      // exhaustive sweep
      for (int v = 0; v < 8; v++) begin
         SW = 3'(v);
         cycles(10);
         check("sweep_ledr", 16'(LEDR), 16'(sweep_tab[v]));
         check("sweep_hex0", 16'(HEX0), 16'(seg_tab[sweep_tab[v]]));
         check("sweep_chg",  16'(CHG),  16'h0);
      end

      // latency 000 -> 111
      SW = 3'd0;
      cycles(6);
      SW = 3'd7;
      cycles(2);
      check("lat_ledr_e2", 16'(LEDR), 16'h0);
      check("lat_chg_e2",  16'(CHG),  16'h0);
      cycles(1);
      check("lat_ledr_e3", 16'(LEDR), 16'h3);
      check("lat_chg_e3",  16'(CHG),  16'h1);
      check("lat_hex_e3",  16'(HEX0), 16'(7'b0110000));
      cycles(1);
      check("lat_ledr_e4", 16'(LEDR), 16'h3);
      check("lat_chg_e4",  16'(CHG),  16'h0);

      // sum unchanged across 001 -> 010
      SW = 3'd1;
      cycles(6);
      SW = 3'd2;
      for (int i = 0; i < 6; i++) begin
         cycles(1);
         check("nochg_ledr", 16'(LEDR), 16'h1);
         check("nochg_chg",  16'(CHG),  16'h0);
      end

      // async reset between edges
      SW = 3'd7;
      cycles(6);
      check("pre_rst_ledr", 16'(LEDR), 16'h3);
      @(posedge CLOCK_50);
      #2 RESET_N = 1'b0;
      #1;
      check("arst_ledr", 16'(LEDR), 16'h0);
      check("arst_hex0", 16'(HEX0), 16'(7'b1000000));
      check("arst_chg",  16'(CHG),  16'h0);
      SW = 3'd3;
      cycles(3);
      RESET_N = 1'b1;
      cycles(1);
      check("rel_ledr_e1", 16'(LEDR), 16'h0);
      cycles(1);
      check("rel_ledr_e2", 16'(LEDR), 16'h0);
      check("rel_chg_e2",  16'(CHG),  16'h0);
      cycles(1);
      check("rel_ledr_e3", 16'(LEDR), 16'h2);
      check("rel_chg_e3",  16'(CHG),  16'h1);
      check("rel_hex_e3",  16'(HEX0), 16'(7'b0100100));

      // short glitch between edges
      SW = 3'd0;
      cycles(6);
      @(posedge CLOCK_50);
      #1 SW = 3'd4;
      #3 SW = 3'd0;
      for (int i = 0; i < 6; i++) begin
         cycles(1);
         check("glitch_ledr", 16'(LEDR), 16'h0);
         check("glitch_chg",  16'(CHG),  16'h0);
      end

      // randomized stimulus, occasional mid-cycle reset
      for (int i = 0; i < 400; i++) begin
         SW = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) begin
            #2 RESET_N = 1'b0;
            cycles($urandom_range(1, 2));
            RESET_N = 1'b1;
         end
         cycles($urandom_range(1, 5));
      end

      cycles(2);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/adder3.md
ADDER3 -- requirements
Module: adder3

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on SW (legal 2..4).
REQ-002 Port: CLOCK_50  input  1  system clock, all state updates on rising edge.
REQ-003 Port: RESET_N  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
REQ-004 Port: SW  input  3  three one-bit addends (A=SW[0], B=SW[1], Cin=SW[2]), asynchronous to CLOCK_50.
REQ-005 Port: LEDR  output  2  registered full-adder result: LEDR[0]=sum, LEDR[1]=carry-out.
REQ-006 Port: HEX0  output  7  active-low seven-segment code of decimal value LEDR (0..3), segment order g..a = bit 6..0.
REQ-007 Port: CHG  output  1  one-cycle pulse, high in the cycle LEDR takes a new value different from its previous value.

Function
REQ-008 SW SHALL pass through a SYNC_STAGES-deep flop chain per bit before use; no combinational path from SW to any output.
REQ-009 Result SHALL equal the unsigned count of ones in synchronized SW: LEDR = SW[0]+SW[1]+SW[2], 2-bit, no overflow possible (max 3 = 2'b11).
REQ-010 Equivalently LEDR[0] SHALL be XOR of the three bits and LEDR[1] SHALL be the majority of the three bits.
REQ-011 LEDR SHALL be a register loaded from the last synchronizer stage every cycle; latency SW change to LEDR = SYNC_STAGES+1 rising edges (3 at default).
REQ-012 HEX0 SHALL be registered, updated in the same cycle as LEDR from the same value: 0 -> 7'b1000000, 1 -> 7'b1111001, 2 -> 7'b0100100, 3 -> 7'b0110000.
REQ-013 CHG SHALL be registered and high for exactly one cycle, the cycle in which the new LEDR value first appears, when new LEDR != previous LEDR; otherwise low.
REQ-014 SW changes held shorter than one clock period MAY be missed; any value stable for at least SYNC_STAGES+1 cycles SHALL appear on LEDR.
REQ-015 Multiple SW bits changing simultaneously SHALL produce only the final correct sum after settling; intermediate values caused by skew between bits are permitted for at most one cycle.
REQ-016 A held SW input SHALL hold LEDR, HEX0 constant and CHG low indefinitely.

Reset
REQ-017 RESET_N low SHALL immediately (without clock) clear all synchronizer flops, LEDR to 2'b00, HEX0 to 7'b1000000, CHG to 0.
REQ-018 Reset mid-operation SHALL discard in-flight synchronizer contents; after RESET_N deasserts, first valid result appears SYNC_STAGES+1 rising edges later.
REQ-019 The first result after reset SHALL raise CHG only if it differs from 0.
REQ-020 RESET_N deassertion is assumed synchronized externally to CLOCK_50; no internal reset synchronizer is required.

Verification
REQ-021 Exhaustive sweep: SW = 0..7, each held 10 cycles -> LEDR = 00,01,01,10,01,10,10,11 respectively, HEX0 matches REQ-012.
REQ-022 Latency: after reset SW 000 -> 111 at edge k -> LEDR=11, CHG=1 visible after edge k+3 (default), CHG=0 after edge k+4.
REQ-023 No-change: SW 001 -> 010 (sum stays 1) -> LEDR remains 01, CHG stays 0.
REQ-024 Async reset: SW=111 settled, LEDR=11; pull RESET_N low between edges -> LEDR=00, HEX0=7'b1000000 at once, before next edge.
REQ-025 Reset release with SW=011 held -> LEDR=00 for 2 edges, LEDR=10 with CHG=1 after the 3rd edge.
REQ-026 Glitch: SW pulse 000 -> 100 -> 000 shorter than half a clock between edges -> LEDR stays 00, CHG stays 0.
